pong_pio_capture: RTL
=====================

PONG_PIO_CAPTURE -- requirements
Module: pong_pio_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 8: input port width, legal range 1..32.
REQ-002 SHALL have parameter EDGE_TYPE, default 0: capture edge; 0 = rising, 1 = falling, 2 = any.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, legal range 2..4.
REQ-004 SHALL have port: clk  input  1  single clock for all logic.
REQ-005 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: address  input  2  Avalon slave word address.
REQ-007 SHALL have port: chipselect  input  1  slave select.
REQ-008 SHALL have port: write_n  input  1  write strobe, active-low.
REQ-009 SHALL have port: writedata  input  32  write data.
REQ-010 SHALL have port: in_port  input  WIDTH  asynchronous external inputs.
REQ-011 SHALL have port: readdata  output  32  registered read data.
REQ-012 SHALL have port: irq  output  1  level interrupt, active-high.

Function
REQ-013 SHALL pass in_port through SYNC_STAGES flip-flops per bit; sync_q is the last stage.
REQ-014 SHALL hold prev_q, which is sync_q delayed by one clk.
REQ-015 SHALL compute edge per bit: rising = sync_q & ~prev_q, falling = ~sync_q & prev_q, any = sync_q ^ prev_q, selected by EDGE_TYPE.
REQ-016 SHALL use this register map: 0 = data (sync_q, RO); 1 = reserved (reads 0); 2 = irqmask (RW); 3 = edgecapture (RW1C).
REQ-017 SHALL zero-extend every register read to 32 bits; bits [31:WIDTH] always read 0.
REQ-018 SHALL register readdata every clk from the mux on address, regardless of chipselect: one-cycle read latency, no wait states.
REQ-019 SHALL take a write only when chipselect=1 and write_n=0.
REQ-020 SHALL ignore writes to addresses 0 and 1.
REQ-021 SHALL load irqmask from writedata[WIDTH-1:0] on a write to address 2.
REQ-022 SHALL set edgecapture bit n on the cycle edge[n]=1; the bit stays set until cleared.
REQ-023 SHALL clear edgecapture bit n on a write to address 3 with writedata[n]=1; bits written 0 are unchanged.
REQ-024 SHALL resolve a same-cycle edge and clear on one bit as set: the edge wins.
REQ-025 SHALL assert irq = |(edgecapture & irqmask), derived combinationally from registers only, with no path from the bus inputs.
REQ-026 SHALL make edgecapture changes visible on readdata one cycle after the register updates.

Reset
REQ-027 SHALL asynchronously clear all synchroniser stages, prev_q, irqmask, edgecapture and readdata to 0 while reset_n=0.
REQ-028 SHALL hold irq at 0 during reset.
REQ-029 SHALL record no edge on the first cycle after reset release, because prev_q and sync_q are both 0.
REQ-030 SHALL abort any bus write in progress when reset asserts mid-operation.

Configuration
REQ-031 SHALL use macro PONG_PIO_IRQ_EN. When defined: irqmask register and irq logic are as specified above.
REQ-032 SHALL, when PONG_PIO_IRQ_EN is undefined: build no irqmask register, make address 2 read 0 and ignore writes to it, tie irq to 0; edge capture remains fully functional.

Structure
REQ-033 SHALL define in package pong_pio_pkg: the address constants (ADDR_DATA=0, ADDR_RSVD=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3) and the EDGE_TYPE encodings.
REQ-034 SHALL implement synchroniser plus edge detection in one sub-module, pong_pio_sync (parameters WIDTH, SYNC_STAGES, EDGE_TYPE; outputs sync_q and edge).

Verification
REQ-035 SHALL test reset state: reset_n=0 with in_port=8'hFF -> readdata=0, irq=0; after release, a read of address 0 returns 0x000000FF after SYNC_STAGES+1 cycles.
REQ-036 SHALL test rising capture: EDGE_TYPE=0, in_port bit 3 goes 0->1 -> address 3 reads 0x00000008; a 1->0 transition captures nothing.
REQ-037 SHALL test W1C: edgecapture=0x0C, write 0x04 to address 3 -> reads 0x08; a write with chipselect=0 causes no change.
REQ-038 SHALL test the collision: edge on bit 0 in the same cycle as a write of 0x01 to address 3 -> bit 0 remains 1.
REQ-039 SHALL test irq with PONG_PIO_IRQ_EN defined: irqmask=0x02, edge on bit 1 -> irq=1; clear bit 1 -> irq=0 on the next cycle; an edge on bit 0 alone -> irq stays 0.
REQ-040 SHALL test the build without PONG_PIO_IRQ_EN: write 0xFF to address 2 -> address 2 reads 0; edges are captured; irq stays 0.

Source files
------------

// File: rtl/pong_pio_pkg.sv
// Shared constants for the pong_pio_capture slice: register word addresses
// and the edge-type encodings used by the EDGE_TYPE parameter.
package pong_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pong_pio_sync.sv
// Multi-stage input synchroniser followed by a one-cycle-delayed copy and a
// per-bit edge detector whose polarity is fixed by EDGE_TYPE.
module pong_pio_sync
    import pong_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_q,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [WIDTH-1:0] stage_reg [SYNC_STAGES];
    logic [WIDTH-1:0] prev_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_reg[i] <= '0;
            end
            prev_reg <= '0;
        end else begin
            stage_reg[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
            prev_reg <= stage_reg[SYNC_STAGES-1];
        end
    end

    assign sync_q = stage_reg[SYNC_STAGES-1];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_edge
            if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
                assign edge_pulse[gi] = ~sync_q[gi] & prev_reg[gi];
            end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
                assign edge_pulse[gi] = sync_q[gi] ^ prev_reg[gi];
            end else begin : g_rise
                assign edge_pulse[gi] = sync_q[gi] & ~prev_reg[gi];
            end
        end
    endgenerate

endmodule

// File: rtl/pong_pio_capture.sv
// Avalon-MM edge-capture PIO: synchronised inputs, sticky W1C edge register,
// optional interrupt mask and level irq enabled by macro PONG_PIO_IRQ_EN.
module pong_pio_capture
    import pong_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int EDGE_TYPE   = EDGE_RISING,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] edgecap_reg;
    logic [WIDTH-1:0] edgecap_next;
    logic [WIDTH-1:0] clear_bits;
    logic [WIDTH-1:0] irqmask_q;
    logic [31:0]      read_mux;
    logic [31:0]      readdata_reg;
    logic             wr_en;
    logic             unused_writedata;

    pong_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .sync_q     (sync_q),
        .edge_pulse (edge_pulse)
    );

    assign wr_en            = chipselect & ~write_n;
    assign clear_bits       = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
    assign unused_writedata = ^writedata;

    // An edge arriving in the same cycle as its clear keeps the bit set.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cap
            assign edgecap_next[gi] = edge_pulse[gi] | (edgecap_reg[gi] & ~clear_bits[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap_reg <= '0;
        end else begin
            edgecap_reg <= edgecap_next;
        end
    end

`ifdef PONG_PIO_IRQ_EN
    logic [WIDTH-1:0] irqmask_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_reg <= '0;
        end else if (wr_en && address == ADDR_IRQMASK) begin
            irqmask_reg <= writedata[WIDTH-1:0];
        end
    end

    assign irqmask_q = irqmask_reg;
    assign irq       = |(edgecap_reg & irqmask_reg);
`else
    assign irqmask_q = '0;
    assign irq       = 1'b0;
`endif

    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DATA:    read_mux[WIDTH-1:0] = sync_q;
            ADDR_IRQMASK: read_mux[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: read_mux[WIDTH-1:0] = edgecap_reg;
            default:      read_mux = '0;
        endcase
    end

    // Read data is refreshed every cycle so a read never needs wait states.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_reg <= '0;
        end else begin
            readdata_reg <= read_mux;
        end
    end

    assign readdata = readdata_reg;

endmodule
